// File: rtl/sincos_pkg.sv
// Shared definitions for the NCO phase generator and the quadratic sin/cos evaluator:
// phase width, quadrant field position and the NCO control state encoding.
package sincos_pkg;

    localparam int PHASE_W = 47;
    localparam int QUAD_HI = 46;
    localparam int QUAD_LO = 45;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nco_state_t;

endpackage

// File: rtl/nco_accum.sv
// Phase accumulator: load has priority over increment; the adder wraps modulo 2^W.
module nco_accum #(
    parameter int W = 47
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] freq_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (inc_i) begin
            acc_d = acc_q + freq_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/nco_phase_gen.sv
// Numerically controlled phase generator feeding the sin/cos evaluator.
// Define NCO_IQ_INTERLEAVE_EN to emit every phase twice (sin then cos).
module nco_phase_gen #(
    parameter int PHASE_W = sincos_pkg::PHASE_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cfg_load,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_offset,
    input  logic [CNT_W-1:0]   burst_len,
    input  logic               cos_sel,
    input  logic               start,
    input  logic               stop,
    input  logic               sample_en,
    output logic [PHASE_W-1:0] phase_o,
    output logic               mode_cos_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o
);
    import sincos_pkg::*;

    nco_state_t         state_q;
    nco_state_t         state_d;
    logic [PHASE_W-1:0] freq_q;
    logic [PHASE_W-1:0] offset_q;
    logic [CNT_W-1:0]   blen_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] phase_q;
    logic               mode_q;
    logic               valid_q;
    logic               cfg_take;
    logic               start_go;
    logic               smp;
    logic               adv;
    logic               last;
    logic               smp_mode;

    // A start coinciding with cfg_load must see the freshly presented offset.
    assign cfg_take = (state_q == IDLE) && cfg_load;
    assign start_go = (state_q == IDLE) && start;
    assign smp      = (state_q == RUN) && sample_en && !stop;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign last     = adv && (blen_q != '0) && (cnt_inc == blen_q);

`ifdef NCO_IQ_INTERLEAVE_EN
    // half_q = 1 means the next sample is the cos half of the current pair.
    logic half_q;

    assign adv      = smp && half_q;
    assign smp_mode = half_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            half_q <= 1'b0;
        end else if (start_go) begin
            half_q <= 1'b0;
        end else if (smp) begin
            half_q <= ~half_q;
        end
    end
`else
    logic cos_sel_q;

    assign adv      = smp;
    assign smp_mode = cos_sel_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cos_sel_q <= 1'b0;
        end else if (cfg_take) begin
            cos_sel_q <= cos_sel;
        end
    end
`endif

    nco_accum #(
        .W (PHASE_W)
    ) u_accum (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (start_go),
        .load_val_i (cfg_take ? phase_offset : offset_q),
        .inc_i      (adv),
        .freq_i     (freq_q),
        .acc_o      (acc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == RUN);
        done_o = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            freq_q   <= '0;
            offset_q <= '0;
            blen_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            mode_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (cfg_take) begin
                freq_q   <= freq_word;
                offset_q <= phase_offset;
                blen_q   <= burst_len;
            end
            if (start_go) begin
                cnt_q <= '0;
            end else if (adv) begin
                cnt_q <= cnt_inc;
            end
            valid_q <= smp;
            if (smp) begin
                phase_q <= acc;
                mode_q  <= smp_mode;
            end
        end
    end

    assign phase_o    = phase_q;
    assign mode_cos_o = mode_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen: vector tables for bursts plus hand sequences
// for continuous runs, stop, ignored controls and asynchronous reset.
module tb_nco_phase_gen;

    localparam int PW = 47;
    localparam int CW = 16;

    logic          clk;
    logic          resetn;
    logic          cfg_load;
    logic [PW-1:0] freq_word;
    logic [PW-1:0] phase_offset;
    logic [CW-1:0] burst_len;
    logic          cos_sel;
    logic          start;
    logic          stop;
    logic          sample_en;
    logic [PW-1:0] phase_o;
    logic          mode_cos_o;
    logic          valid_o;
    logic          busy_o;
    logic          done_o;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic          cfg;
        logic          st;
        logic          smp;
        logic          stp;
        logic          ev;
        logic [PW-1:0] ep;
        logic          em;
        logic          eb;
        logic          ed;
    } vec_t;

    vec_t vecs[$];

    nco_phase_gen #(
        .PHASE_W (PW),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cfg_load     (cfg_load),
        .freq_word    (freq_word),
        .phase_offset (phase_offset),
        .burst_len    (burst_len),
        .cos_sel      (cos_sel),
        .start        (start),
        .stop         (stop),
        .sample_en    (sample_en),
        .phase_o      (phase_o),
        .mode_cos_o   (mode_cos_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [PW-1:0] ep,
                           input logic em, input logic eb, input logic ed);
        chk({tag, " valid"}, 64'(valid_o), 64'(ev));
        chk({tag, " phase"}, 64'(phase_o), 64'(ep));
        chk({tag, " mode"},  64'(mode_cos_o), 64'(em));
        chk({tag, " busy"},  64'(busy_o), 64'(eb));
        chk({tag, " done"},  64'(done_o), 64'(ed));
    endtask

    task automatic add(input logic cfg, input logic st, input logic smp, input logic stp,
                       input logic ev, input logic [PW-1:0] ep, input logic em,
                       input logic eb, input logic ed);
        vec_t v;
        v.cfg = cfg; v.st = st; v.smp = smp; v.stp = stp;
        v.ev = ev; v.ep = ep; v.em = em; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic run_table(input string seg);
        for (int i = 0; i < vecs.size(); i++) begin
            cfg_load  = vecs[i].cfg;
            start     = vecs[i].st;
            sample_en = vecs[i].smp;
            stop      = vecs[i].stp;
            tick();
            chk_out($sformatf("%s[%0d]", seg, i), vecs[i].ev, vecs[i].ep,
                    vecs[i].em, vecs[i].eb, vecs[i].ed);
        end
        vecs.delete();
        cfg_load = 0; start = 0; sample_en = 0; stop = 0;
    endtask

    task automatic clear_inputs();
        cfg_load = 0; start = 0; stop = 0; sample_en = 0; cos_sel = 0;
        freq_word = '0; phase_offset = '0; burst_len = '0;
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        repeat (3) tick();
        chk_out("reset", 0, '0, 0, 0, 0);
        resetn = 1'b1;
        tick();
        chk_out("post_reset", 0, '0, 0, 0, 0);

`ifdef NCO_IQ_INTERLEAVE_EN
        // Burst of two sin/cos pairs.
        freq_word = 47'h100; phase_offset = '0; burst_len = 16'd2;
        add(1, 1, 0, 0, 0, 47'h0,   0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0,   0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0,   1, 1, 0);
        add(0, 0, 1, 0, 1, 47'h100, 0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h100, 1, 0, 1);
        add(0, 0, 1, 0, 0, 47'h100, 1, 0, 0);
        run_table("iq_burst");

        // Stop mid-pair: cos half is dropped, restart begins with sin.
        burst_len = '0;
        add(1, 1, 0, 0, 0, 47'h100, 1, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0,   0, 1, 0);
        add(0, 0, 1, 1, 0, 47'h0,   0, 0, 0);
        add(0, 1, 0, 0, 0, 47'h0,   0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0,   0, 1, 0);
        add(0, 0, 0, 1, 0, 47'h0,   0, 0, 0);
        run_table("iq_stop");
`else
        // Burst of four, phase step 0x1000_0000.
        freq_word = 47'h0_1000_0000; phase_offset = '0; burst_len = 16'd4; cos_sel = 0;
        add(1, 1, 0, 0, 0, 47'h0,         0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0,         0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h1000_0000, 0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h2000_0000, 0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h3000_0000, 0, 0, 1);
        add(0, 0, 1, 0, 0, 47'h3000_0000, 0, 0, 0);
        add(0, 0, 1, 0, 0, 47'h3000_0000, 0, 0, 0);
        run_table("burst4");

        // Quadrant 3 start wrapping through zero, cos selected.
        freq_word = 47'h2000_0000_0000; phase_offset = 47'h6000_0000_0000;
        burst_len = 16'd3; cos_sel = 1;
        add(1, 1, 0, 0, 0, 47'h3000_0000,      0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h6000_0000_0000, 1, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0,              1, 1, 0);
        add(0, 0, 1, 0, 1, 47'h2000_0000_0000, 1, 0, 1);
        add(0, 0, 0, 0, 0, 47'h2000_0000_0000, 1, 0, 0);
        run_table("wrap3");

        // Single-sample burst.
        freq_word = 47'h1; phase_offset = 47'h7; burst_len = 16'd1; cos_sel = 0;
        add(1, 1, 0, 0, 0, 47'h2000_0000_0000, 1, 1, 0);
        add(0, 0, 1, 0, 1, 47'h7,              0, 0, 1);
        add(0, 0, 0, 0, 0, 47'h7,              0, 0, 0);
        run_table("burst1");

        // Continuous run from latched config; mid-run cfg_load/start ignored.
        freq_word = 47'h10; phase_offset = 47'h5; burst_len = '0; cos_sel = 0;
        cfg_load = 1;
        tick();
        chk_out("cont_cfg", 0, 47'h7, 0, 0, 0);
        cfg_load = 0;
        freq_word = 47'h777; phase_offset = 47'h333;
        start = 1;
        tick();
        chk_out("cont_start", 0, 47'h7, 0, 1, 0);
        start = 0;
        for (int k = 0; k < 10; k++) begin
            sample_en = 1;
            tick();
            sample_en = 0;
            chk_out($sformatf("cont_s%0d", k), 1, PW'(5 + 16 * k), 0, 1, 0);
            for (int g = 0; g < 2; g++) begin
                if (k == 3 && g == 0) begin
                    cfg_load = 1; start = 1; freq_word = 47'h999;
                end
                tick();
                cfg_load = 0; start = 0;
                chk_out($sformatf("cont_gap%0d_%0d", k, g), 0, PW'(5 + 16 * k), 0, 1, 0);
            end
        end
        sample_en = 1; stop = 1;
        tick();
        sample_en = 0; stop = 0;
        chk_out("cont_stop", 0, 47'h95, 0, 0, 0);
        tick();
        chk_out("cont_after", 0, 47'h95, 0, 0, 0);

        // Asynchronous reset mid-burst, then restart with zeroed config.
        freq_word = 47'h40; phase_offset = '0; burst_len = 16'd8;
        add(1, 1, 0, 0, 0, 47'h95, 0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0,  0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h40, 0, 1, 0);
        run_table("pre_rst");
        sample_en = 1;
        #2 resetn = 1'b0;
        #1;
        chk_out("async_rst", 0, '0, 0, 0, 0);
        tick();
        chk_out("rst_held", 0, '0, 0, 0, 0);
        resetn = 1'b1;
        sample_en = 0;
        add(0, 1, 0, 0, 0, 47'h0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 47'h0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 47'h0, 0, 0, 0);
        run_table("post_rst");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
# nco_phase_gen

Numerically controlled phase generator feeding the quadratic sin/cos evaluator. Holds a 47-bit phase accumulator that advances by a programmable frequency word on each sample strobe. Emits phase, function select and valid in the exact format the evaluator consumes: `phase[46:45]` is the quadrant, `mode_cos` selects cos. Supports finite bursts or continuous runs, started and stopped by control pulses.

## Interface
Parameters:
- `PHASE_W`, 47: accumulator and phase width; must equal the evaluator's phase width.
- `CNT_W`, 16: burst-length counter width.

Ports:
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `cfg_load`  in  1  latch configuration inputs; honoured only in IDLE.
- `freq_word`  in  PHASE_W  phase increment per output sample.
- `phase_offset`  in  PHASE_W  initial accumulator value at start.
- `burst_len`  in  CNT_W  samples per burst; 0 = continuous.
- `cos_sel`  in  1  function select latched with config (non-interleave build).
- `start`  in  1  pulse; IDLE→RUN.
- `stop`  in  1  pulse; abort RUN.
- `sample_en`  in  1  rate strobe; one sample per asserted cycle in RUN.
- `phase_o`  out  PHASE_W  phase to evaluator.
- `mode_cos_o`  out  1  function select to evaluator.
- `valid_o`  out  1  sample qualifier.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle pulse at burst completion.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. On reset, all outputs are 0, all config registers are 0, and the accumulator and counter are 0.
- IDLE:
  - `cfg_load` latches `freq_word`, `phase_offset`, `burst_len` and `cos_sel`.
  - `start` loads acc←offset and cnt←0, then → RUN.
  - `cfg_load` and `start` in the same cycle: the start uses the newly presented values.
- RUN, on `sample_en` with no `stop`:
  - phase_o←acc, valid_o←1, acc←(acc+freq) mod 2^PHASE_W, cnt←cnt+1.
  - If burst_len≠0 and cnt+1==burst_len, → DONE.
- RUN, `stop` asserted: → IDLE. `stop` has priority over a coincident `sample_en`, so no sample is emitted that cycle. `done_o` is not pulsed.
- DONE: `done_o`=1 for one cycle, then → IDLE. Strobes are ignored in DONE.
- `start` in RUN or DONE is ignored. `cfg_load` outside IDLE is ignored, and config stays stable during a burst.
- Accumulator wraps silently. Quadrant bits wrap 3→0 naturally.
- Continuous mode (burst_len=0): cnt wraps at 2^CNT_W with no effect. The run ends only on `stop`.
- `valid_o` is low on every cycle without a qualifying sample. `phase_o` and `mode_cos_o` hold their last values when invalid.

## Timing
- Registered outputs: `valid_o`/`phase_o` appear one cycle after the qualifying `sample_en` edge.
- `busy_o` is high in the cycle after `start` is sampled and drops in the cycle after the final sample or the `stop`.
- `done_o` asserts in the same cycle as the final sample's `valid_o`.
- Back-to-back `sample_en` yields back-to-back valid samples at full clock rate. There is no backpressure, because the evaluator is a fixed pipeline.
- A reset assertion mid-burst forces IDLE and zeroed outputs immediately (asynchronously). The first `start` after reset is accepted once `resetn` is released.

## Configuration
- Macro: `NCO_IQ_INTERLEAVE_EN`.
- Defined:
  - Each phase value is emitted twice on consecutive qualifying strobes, first `mode_cos_o`=0 (sin), then `mode_cos_o`=1 (cos).
  - acc advances only after the cos sample.
  - cnt counts pairs, so a burst ends after the cos of pair `burst_len`.
  - `cos_sel` is unused.
  - `stop` mid-pair aborts without emitting the cos half.
- Undefined: `mode_cos_o` = latched `cos_sel` on every sample; one sample per phase.

## Structure
- Shared package `sincos_pkg`: `PHASE_W`=47, the quadrant field position [46:45], and the state enum `nco_state_t` {IDLE, RUN, DONE}. The evaluator and this block both import it.
- One natural sub-module, `nco_accum`: accumulator register with load and increment enables plus the wrap adder. The FSM and counter stay in the top.

## Test plan
- Reset, then freq=0x0000_1000_0000, offset=0, burst_len=4, cos_sel=0, start, four consecutive strobes → phases 0x0, 0x1000_0000, 0x2000_0000, 0x3000_0000; `done_o` with the 4th sample; `busy_o` low afterwards.
- offset=0x6000_0000_0000 (quadrant 3), freq=0x2000_0000_0000, burst_len=3 → phases 0x6000_0000_0000, 0x0000_0000_0000, 0x2000_0000_0000 (wrap verified).
- burst_len=0, strobes every 3rd cycle, `stop` after 10 samples → exactly 10 valids spaced 3 cycles apart; no `done_o`; `stop`+`sample_en` in the same cycle emits nothing.
- `cfg_load` with new freq during RUN → ignored (phase step unchanged); `start` during RUN → ignored.
- `resetn` low mid-burst → `valid_o`/`busy_o` 0 immediately; a subsequent start uses post-reset config (freq 0 → constant phase = offset 0).
- With `NCO_IQ_INTERLEAVE_EN`, freq=0x100, burst_len=2 → (0x0,sin), (0x0,cos), (0x100,sin), (0x100,cos); `done_o` on the 4th sample.
